// File: rtl/snn_layer_sched_pkg.sv
// Shared definitions for the SNN layer scheduler: default sizing, a
// clog2 helper that never yields a zero-width vector, the width
// constants derived from the default sizing, and the FSM state encoding.
package snn_layer_sched_pkg;

    localparam int DEF_PRE_SYN_LAYER_SIZE = 16;
    localparam int DEF_NUM_UNITS          = 4;
    localparam int DEF_NEURAL_SIZE        = 4;
    localparam int DEF_NUM_TIMESTEPS      = 8;
    localparam int DEF_ACCUM_CYCLES       = 3;
    localparam int DEF_ACTIV_CYCLES       = 2 * DEF_NEURAL_SIZE + 1;

    // Bits needed to hold indices 0..value-1, with a floor of one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Larger of two counts, used to size the shared cycle counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DEF_ACCUM_LEN = DEF_ACCUM_CYCLES * DEF_NEURAL_SIZE;
    localparam int DEF_ADDR_W    = clog2_min1(DEF_PRE_SYN_LAYER_SIZE);
    localparam int DEF_CNT_W     = clog2_min1(max_int(DEF_ACCUM_LEN, DEF_ACTIV_CYCLES));
    localparam int DEF_TS_W      = clog2_min1(DEF_NUM_TIMESTEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SCAN    = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_ACTIV   = 3'd4,
        ST_COLLECT = 3'd5,
        ST_OUT     = 3'd6,
        ST_FIN     = 3'd7
    } state_e;

endpackage

// File: rtl/snn_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the least
// significant set bit of vec and whether any bit is set.
module snn_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = vec[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/snn_layer_sched.sv
// SNN layer scheduler: per timestep, accepts an input spike vector,
// walks its set bits lowest-first issuing one accumulate burst per spike
// to all neural units, fires one activation pulse, captures the units'
// spikes and hands them to the consumer. Repeats for NUM_TIMESTEPS.
// Outputs are registered copies decoded from the next state so they line
// up cycle-for-cycle with the state register.
module snn_layer_sched
    import snn_layer_sched_pkg::*;
#(
    parameter int PRE_SYN_LAYER_SIZE = DEF_PRE_SYN_LAYER_SIZE,
    parameter int NUM_UNITS          = DEF_NUM_UNITS,
    parameter int NEURAL_SIZE        = DEF_NEURAL_SIZE,
    parameter int NUM_TIMESTEPS      = DEF_NUM_TIMESTEPS,
    parameter int ACCUM_CYCLES       = DEF_ACCUM_CYCLES,
    parameter int ACTIV_CYCLES       = 2 * NEURAL_SIZE + 1,
    localparam int ADDR_W            = clog2_min1(PRE_SYN_LAYER_SIZE),
    localparam int OUT_W             = NUM_UNITS * NEURAL_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PRE_SYN_LAYER_SIZE-1:0] in_spk,
    output logic                          en_accum,
    output logic                          en_activ,
    output logic [ADDR_W-1:0]             spk_addr,
    input  logic [OUT_W-1:0]              unit_spk,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_spk,
    output logic                          busy,
    output logic                          done
);

    localparam int ACCUM_LEN = ACCUM_CYCLES * NEURAL_SIZE;
    localparam int CNT_W     = clog2_min1(max_int(ACCUM_LEN, ACTIV_CYCLES));
    localparam int TS_W      = clog2_min1(NUM_TIMESTEPS + 1);

    localparam logic [CNT_W-1:0] ACCUM_LAST = CNT_W'(ACCUM_LEN - 1);
    localparam logic [CNT_W-1:0] ACTIV_LAST = CNT_W'(ACTIV_CYCLES - 1);
    localparam logic [TS_W-1:0]  TS_FINAL   = TS_W'(NUM_TIMESTEPS);

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [TS_W-1:0]                 ts_q, ts_d;
    logic [TS_W-1:0]                 ts_inc_s;
    logic [PRE_SYN_LAYER_SIZE-1:0]   pending_q, pending_d;
    logic [ADDR_W-1:0]               spk_addr_q, spk_addr_d;
    logic [OUT_W-1:0]                out_spk_q, out_spk_d;
    logic                            in_ready_q, in_ready_d;
    logic                            en_accum_q, en_accum_d;
    logic                            en_activ_q, en_activ_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [ADDR_W-1:0]               pend_idx_s;
    logic                            pend_any_s;

    snn_prio_enc #(
        .WIDTH (PRE_SYN_LAYER_SIZE),
        .IDX_W (ADDR_W)
    ) u_prio_enc (
        .vec (pending_q),
        .idx (pend_idx_s),
        .any (pend_any_s)
    );

    assign ts_inc_s = ts_q + TS_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = start ? ST_LOAD : ST_IDLE;
            ST_LOAD:    state_d = in_valid ? ST_SCAN : ST_LOAD;
            ST_SCAN:    state_d = pend_any_s ? ST_ACCUM : ST_ACTIV;
            ST_ACCUM:   state_d = (cnt_q == ACCUM_LAST) ? ST_SCAN : ST_ACCUM;
            ST_ACTIV:   state_d = (cnt_q == ACTIV_LAST) ? ST_COLLECT : ST_ACTIV;
            ST_COLLECT: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_d = (ts_inc_s == TS_FINAL) ? ST_FIN : ST_LOAD;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state; en_activ only on entry to ACTIV.
    always_comb begin
        in_ready_d  = (state_d == ST_LOAD);
        en_accum_d  = (state_d == ST_ACCUM);
        en_activ_d  = (state_d == ST_ACTIV) && (state_q != ST_ACTIV);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
    end

    // Cycle counter for ACCUM and ACTIV dwell, timestep counter.
    always_comb begin
        cnt_d = '0;
        ts_d  = ts_q;
        case (state_q)
            ST_IDLE: begin
                ts_d = start ? '0 : ts_q;
            end
            ST_ACCUM: begin
                cnt_d = (cnt_q == ACCUM_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            ST_ACTIV: begin
                cnt_d = (cnt_q == ACTIV_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            ST_OUT: begin
                ts_d = out_ready ? ts_inc_s : ts_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath: pending spikes, current spike index, captured layer output.
    always_comb begin
        pending_d  = pending_q;
        spk_addr_d = spk_addr_q;
        out_spk_d  = out_spk_q;
        case (state_q)
            ST_LOAD: begin
                pending_d = in_valid ? in_spk : pending_q;
            end
            ST_SCAN: begin
                if (pend_any_s) begin
                    pending_d[pend_idx_s] = 1'b0;
                    spk_addr_d            = pend_idx_s;
                end else begin
                    spk_addr_d = spk_addr_q;
                end
            end
            ST_COLLECT: begin
                out_spk_d = unit_spk;
            end
            default: begin
                pending_d = pending_q;
            end
        endcase
    end

    // Counters, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            ts_q        <= '0;
            pending_q   <= '0;
            spk_addr_q  <= '0;
            out_spk_q   <= '0;
            in_ready_q  <= 1'b0;
            en_accum_q  <= 1'b0;
            en_activ_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ts_q        <= ts_d;
            pending_q   <= pending_d;
            spk_addr_q  <= spk_addr_d;
            out_spk_q   <= out_spk_d;
            in_ready_q  <= in_ready_d;
            en_accum_q  <= en_accum_d;
            en_activ_q  <= en_activ_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign en_accum  = en_accum_q;
    assign en_activ  = en_activ_q;
    assign spk_addr  = spk_addr_q;
    assign out_valid = out_valid_q;
    assign out_spk   = out_spk_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_snn_layer_sched.sv
// Directed bench for snn_layer_sched with default parameters.
module tb_snn_layer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_spk;
    logic        en_accum;
    logic        en_activ;
    logic [3:0]  spk_addr;
    logic [15:0] unit_spk;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_spk;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    typedef struct {
        logic [15:0] in_spk;
        logic [15:0] unit_spk;
        int          ready_delay;
        int          exp_accum;
        int          exp_lat;
    } vec_t;

    vec_t tbl [8];

    snn_layer_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_spk    (in_spk),
        .en_accum  (en_accum),
        .en_activ  (en_activ),
        .spk_addr  (spk_addr),
        .unit_spk  (unit_spk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_spk   (out_spk),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 0);
        check("rst_en_accum", en_accum, 0);
        check("rst_en_activ", en_activ, 0);
        check("rst_spk_addr", spk_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_spk", out_spk, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    // One full timestep driven from table row r; called at a negedge in LOAD.
    task automatic run_ts(input int r, input bit last);
        int   exp_addr[$];
        int   guard;
        int   cyc;
        int   accum_cnt;
        int   activ_cnt;
        int   bursts;
        int   burst_len;
        int   addr_moves;
        int   busy_low;
        logic prev_acc;
        logic [3:0] held_addr;
        bit   got;

        exp_addr = {};
        for (int b = 0; b < 16; b++) begin
            if (tbl[r].in_spk[b]) exp_addr.push_back(b);
        end
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("load_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_spk   = tbl[r].in_spk;
        unit_spk = tbl[r].unit_spk;
        @(negedge clk);
        in_valid = 1'b0;
        in_spk   = 16'h0000;
        check("scan_in_ready_low", in_ready, 0);

        cyc = 1; got = 0; accum_cnt = 0; activ_cnt = 0; bursts = 0;
        burst_len = 0; addr_moves = 0; busy_low = 0; prev_acc = 1'b0; held_addr = 4'd0;
        while (cyc <= 400 && !got) begin
            if (out_valid) begin
                got = 1;
            end else begin
                if (!busy) busy_low++;
                if (en_accum) begin
                    if (!prev_acc) begin
                        bursts++;
                        burst_len = 0;
                        held_addr = spk_addr;
                        if (bursts <= exp_addr.size())
                            check("spk_addr_seq", spk_addr, exp_addr[bursts-1]);
                    end else if (spk_addr !== held_addr) begin
                        addr_moves++;
                    end
                    burst_len++;
                    accum_cnt++;
                end else if (prev_acc) begin
                    check("accum_burst_len", burst_len, 12);
                end
                if (en_activ) activ_cnt++;
                prev_acc = en_accum;
                @(negedge clk);
                cyc++;
            end
        end
        check("out_valid_seen", got, 1);
        check("out_latency", cyc, tbl[r].exp_lat);
        check("accum_cycles", accum_cnt, tbl[r].exp_accum);
        check("accum_bursts", bursts, exp_addr.size());
        check("activ_pulses", activ_cnt, 1);
        check("spk_addr_stable", addr_moves, 0);
        check("busy_during_ts", busy_low, 0);

        unit_spk = ~tbl[r].unit_spk;
        for (int d = 0; d < tbl[r].ready_delay; d++) begin
            check("out_hold_valid", out_valid, 1);
            check("out_hold_data", out_spk, tbl[r].unit_spk);
            start = (d == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_spk", out_spk, tbl[r].unit_spk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        if (done) done_seen++;
        check("done_timing", done, last);
    endtask

    initial begin
        int guard;
        tbl[0] = '{16'h0005, 16'hA5C3, 5, 24, 38};
        tbl[1] = '{16'h0000, 16'h1234, 0, 0, 12};
        tbl[2] = '{16'h8000, 16'h0F0F, 1, 12, 25};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 0, 192, 220};
        tbl[4] = '{16'h0100, 16'h8001, 2, 12, 25};
        tbl[5] = '{16'h00F0, 16'h5A5A, 0, 48, 64};
        tbl[6] = '{16'h0000, 16'h0000, 3, 0, 12};
        tbl[7] = '{16'h4002, 16'h3C3C, 0, 24, 38};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_spk = 16'h0000;
        unit_spk = 16'h0000; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 0);

        // Full inference of eight timesteps.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        done_seen = 0;
        for (int r = 0; r < 8; r++) run_ts(r, r == 7);
        @(negedge clk);
        check("run1_done_low", done, 0);
        check("run1_busy_low", busy, 0);
        check("run1_done_count", done_seen, 1);

        // Abort during ACCUM of timestep 3.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_seen = 0;
        for (int r = 0; r < 3; r++) run_ts(r, 1'b0);
        check("ts3_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_spk   = 16'h0010;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!en_accum && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ts3_in_accum", en_accum, 1);
        check("ts3_addr", spk_addr, 4);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_busy_low", busy, 0);

        // Fresh inference after the abort must run all eight timesteps.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_seen = 0;
        for (int r = 0; r < 8; r++) run_ts(r, r == 7);
        @(negedge clk);
        check("run2_done_low", done, 0);
        check("run2_busy_low", busy, 0);
        check("run2_done_count", done_seen, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
